mem_access_stage: RTL

//  - MEM stage directly downstream of the execute ALU.
//  - Takes the ALU result as either a load/store address or a pass-through value.
//  - Runs the data-memory handshake: byte-lane alignment, store byte enables, load sign/zero extension.
//  - Hands a single registered result to writeback.
//  - Multi-cycle. Stalls execute via req_ready until memory acks or the access times out.

---
 rtl/mem_access_stage_if.sv | 20 ++
 rtl/mem_access_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: load/store handshake with lane alignment, extension and timeout.
// Optional macro MISALIGN_TRAP_EN: misaligned H/W accesses fault without a bus request.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  mem_access_stage_if.master mem,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        bus_error
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_reg;
  logic [7:0]  timer_reg;
  logic [1:0]  size_reg;
  logic [1:0]  off_reg;
  logic        load_reg;
  logic        unsigned_reg;
  logic        mem_req_reg;
  logic        mem_we_reg;
  logic [31:0] mem_addr_reg;
  logic [3:0]  mem_be_reg;
  logic [31:0] mem_wdata_reg;
  logic        wb_we_reg;
  logic [4:0]  wb_rd_reg;
  logic [31:0] wb_data_reg;
  logic        bus_error_reg;

  logic [1:0]  size_in;
  logic [1:0]  off_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] rdata_shifted;
  logic [31:0] load_value;

  // Encodings 011/110/111 fall into the word class.
  always_comb begin
    size_in = SZ_W;
    case (funct3[1:0])
      2'b00:   size_in = SZ_B;
      2'b01:   size_in = SZ_H;
      default: size_in = SZ_W;
    endcase
  end

  always_comb begin
    off_in   = 2'b00;
    be_in    = 4'b1111;
    wdata_in = store_data;
    case (size_in)
      SZ_B: begin
        off_in   = alu_result[1:0];
        be_in    = 4'b0001 << alu_result[1:0];
        wdata_in = {4{store_data[7:0]}};
      end
      SZ_H: begin
        off_in   = {alu_result[1], 1'b0};
        be_in    = 4'b0011 << {alu_result[1], 1'b0};
        wdata_in = {2{store_data[15:0]}};
      end
      default: begin
        off_in   = 2'b00;
        be_in    = 4'b1111;
        wdata_in = store_data;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((size_in == SZ_H) && alu_result[0]) ||
                      ((size_in == SZ_W) && (alu_result[1:0] != 2'b00));
`endif

  assign rdata_shifted = mem.mem_rdata >> {off_reg, 3'b000};

  always_comb begin
    load_value = mem.mem_rdata;
    case (size_reg)
      SZ_B: load_value = unsigned_reg ? {24'd0, rdata_shifted[7:0]}
                                      : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      SZ_H: load_value = unsigned_reg ? {16'd0, rdata_shifted[15:0]}
                                      : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_value = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= 8'd0;
      size_reg      <= SZ_B;
      off_reg       <= 2'b00;
      load_reg      <= 1'b0;
      unsigned_reg  <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'd0;
      mem_be_reg    <= 4'd0;
      mem_wdata_reg <= 32'd0;
      wb_we_reg     <= 1'b0;
      wb_rd_reg     <= 5'd0;
      wb_data_reg   <= 32'd0;
      bus_error_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            size_reg     <= size_in;
            off_reg      <= off_in;
            load_reg     <= is_load;
            unsigned_reg <= funct3[2];
            wb_rd_reg    <= rd_in;
            if (is_load || is_store) begin
`ifdef MISALIGN_TRAP_EN
              if (misaligned) begin
                state_reg     <= ST_RESP;
                wb_we_reg     <= 1'b0;
                wb_data_reg   <= alu_result;
                bus_error_reg <= 1'b1;
              end else
`endif
              begin
                state_reg     <= ST_ACCESS;
                timer_reg     <= 8'd0;
                mem_req_reg   <= 1'b1;
                mem_we_reg    <= is_store;
                mem_addr_reg  <= {alu_result[31:2], 2'b00};
                mem_be_reg    <= be_in;
                mem_wdata_reg <= wdata_in;
              end
            end else begin
              state_reg     <= ST_RESP;
              wb_we_reg     <= (rd_in != 5'd0);
              wb_data_reg   <= alu_result;
              bus_error_reg <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          // An ack landing on the expiry cycle completes normally.
          if (mem.mem_ack || (timer_reg == TIMER_LAST)) begin
            state_reg     <= ST_RESP;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_be_reg    <= 4'd0;
            mem_wdata_reg <= 32'd0;
            if (mem.mem_ack) begin
              wb_we_reg     <= load_reg && (wb_rd_reg != 5'd0);
              wb_data_reg   <= load_reg ? load_value : 32'd0;
              bus_error_reg <= 1'b0;
            end else begin
              wb_we_reg     <= 1'b0;
              wb_data_reg   <= 32'd0;
              bus_error_reg <= 1'b1;
            end
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          wb_we_reg     <= 1'b0;
          wb_rd_reg     <= 5'd0;
          wb_data_reg   <= 32'd0;
          bus_error_reg <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = (state_reg == ST_IDLE);
  assign wb_valid      = (state_reg == ST_RESP);
  assign wb_we         = wb_we_reg;
  assign wb_rd         = wb_rd_reg;
  assign wb_data       = wb_data_reg;
  assign bus_error     = bus_error_reg;
  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_be    = mem_be_reg;
  assign mem.mem_wdata = mem_wdata_reg;

endmodule
